// File: rtl/gf_seq_div_pkg.sv
// Shared defaults and FSM state encoding for the sequential GF(2^M) divider.
package gf_seq_div_pkg;

  localparam int         DEF_M    = 8;
  localparam logic [8:0] DEF_POLY = 9'h15F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gf_seq_div_mul.sv
// Combinational GF(2^M) multiplier: MSB-first shift-and-add with reduction
// folded into every step, so no intermediate ever grows beyond M bits.
module gf_mul_par
  import gf_seq_div_pkg::*;
#(
  parameter int         M    = DEF_M,
  parameter logic [M:0] POLY = (M+1)'(DEF_POLY)
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p
);

  always_comb begin
    p = '0;
    for (int i = M - 1; i >= 0; i--) begin
      p = {p[M-2:0], 1'b0} ^ (p[M-1] ? POLY[M-1:0] : '0) ^ (b[i] ? a : '0);
    end
  end

endmodule

// File: rtl/gf_seq_div.sv
// Sequential GF(2^M) divider: out_c = in_a * in_b^(2^M-2), one square-and-multiply
// step per cycle. Define GF_DIV_ERR_EN to add the div_err (zero divisor) output.
module gf_seq_div
  import gf_seq_div_pkg::*;
#(
  parameter int         M    = DEF_M,
  parameter logic [M:0] POLY = (M+1)'(DEF_POLY)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_a,
  input  logic [M-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_c
`ifdef GF_DIV_ERR_EN
  ,
  output logic         div_err
`endif
);

  localparam int CW = $clog2(M);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [M-1:0]    sq;
  logic [M-1:0]    acc;
  logic [M-1:0]    sq_nxt;
  logic [M-1:0]    prod;

  gf_mul_par #(.M(M), .POLY(POLY)) u_sq (
    .a (sq),
    .b (sq),
    .p (sq_nxt)
  );

  gf_mul_par #(.M(M), .POLY(POLY)) u_acc (
    .a (acc),
    .b (sq_nxt),
    .p (prod)
  );

  assign out_c = acc;

`ifdef GF_DIV_ERR_EN
  logic err;
  assign div_err = err;
`endif

  // M-1 squaring steps accumulate b^2 * b^4 * ... * b^(2^(M-1)); the cycle with
  // cnt==0 hands over to DONE, giving a fixed M-cycle latency for every operand.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      sq        <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef GF_DIV_ERR_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sq       <= in_b;
            acc      <= in_a;
            cnt      <= CW'(M - 1);
            in_ready <= 1'b0;
            state    <= CALC;
`ifdef GF_DIV_ERR_EN
            err      <= (in_b == '0);
`endif
          end
        end
        CALC: begin
          if (cnt != '0) begin
            sq  <= sq_nxt;
            acc <= prod;
            cnt <= cnt - 1'b1;
          end else begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
`ifdef GF_DIV_ERR_EN
            err       <= 1'b0;
`endif
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
